rr_arbiter2x1: RTL and testbench

RR_ARBITER2X1 -- requirements
Module: rr_arbiter2x1

---
 rtl/arb_pkg.sv | 14 +
 rtl/mux2x1.sv | 17 +
 rtl/rr_arbiter2x1.sv | 125 ++++++++++++
 tb/tb_rr_arbiter2x1.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester round-robin arbiter.
//   arb_state_e : output register occupancy (EMPTY / FULL)
//   REQ0, REQ1  : requester index encodings used for grant, out_src, last_grant
package arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mux2x1.sv
// Generic 2:1 multiplexer.
//   sel : 0 selects d0, 1 selects d1
//   d0  : input word 0 (DW bits)
//   d1  : input word 1 (DW bits)
//   y   : selected word (DW bits)
module mux2x1 #(
  parameter int DW = 8
) (
  input  logic          sel,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  output logic [DW-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/rr_arbiter2x1.sv
// Two-requester round-robin arbiter feeding a single registered output slot.
//   clk, rst                        : clock, synchronous active-high reset
//   req0_valid/req0_data/req0_ready : requester 0 valid/ready handshake
//   req1_valid/req1_data/req1_ready : requester 1 valid/ready handshake
//   out_valid/out_data/out_src      : registered output word and its source index
//   out_ready                       : downstream consumes the output word
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | output register holds no word
// FULL  | output register holds a word (out_valid = 1)
module rr_arbiter2x1
  import arb_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_src,
  input  logic          out_ready
);

  arb_state_e    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_src_q, out_src_d;

  logic          grant;
  logic          can_accept;
  logic          accept;
  logic [DW-1:0] grant_data;

  // Grant: sole valid requester wins; on contention the one not served last wins.
  // With nobody valid the value is irrelevant since no ready can assert.
  always_comb begin
    grant = last_grant_q;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req0_valid) begin
      grant = REQ0;
    end else if (req1_valid) begin
      grant = REQ1;
    end
  end

  mux2x1 #(
    .DW (DW)
  ) u_data_mux (
    .sel (grant),
    .d0  (req0_data),
    .d1  (req1_data),
    .y   (grant_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        // A simultaneous accept refills the slot as it drains: one word per cycle.
        if (out_ready && !accept) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Output logic. Readys are held low during reset so nothing is taken
  // from a requester while the slot is being cleared.
  always_comb begin
    out_valid  = (state_q == FULL);
    can_accept = !rst && ((state_q == EMPTY) || out_ready);
    req0_ready = can_accept && (grant == REQ0) && req0_valid;
    req1_ready = can_accept && (grant == REQ1) && req1_valid;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  end

  // Datapath and round-robin pointer; last_grant moves only on an accept.
  always_comb begin
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      out_data_d   = grant_data;
      out_src_d    = grant;
      last_grant_d = grant;
    end
  end

  // Reset leaves last_grant at REQ1 so the first contended grant goes to REQ0.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_src_q    <= REQ0;
      last_grant_q <= REQ1;
    end else begin
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data = out_data_q;
  assign out_src  = out_src_q;

endmodule

// File: tb/tb_rr_arbiter2x1.sv
// Directed self-checking bench for rr_arbiter2x1.
// Inputs change 1 time unit after the rising edge; everything is checked on
// the falling edge.
module tb_rr_arbiter2x1;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic          out_ready;

  int n_total = 0;
  int n_pass  = 0;

  rr_arbiter2x1 #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply inputs just after a rising edge, then wait for the falling edge.
  task automatic drive(input logic r, input logic v0, input logic [DW-1:0] d0,
                       input logic v1, input logic [DW-1:0] d1, input logic ordy);
    @(posedge clk);
    #1;
    rst        = r;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    out_ready  = ordy;
    @(negedge clk);
  endtask

  // Protocol monitor with an independent round-robin pointer model.
  logic          mdl_last = 1'b1;
  logic          mdl_grant;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data;

  always @(negedge clk) begin
    if (req0_valid && req1_valid) mdl_grant = ~mdl_last;
    else mdl_grant = req1_valid;
    chk("ready_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
    if (req0_ready) chk("ready0_grant", {31'd0, req0_valid & ~mdl_grant}, 32'd1);
    if (req1_ready) chk("ready1_grant", {31'd0, req1_valid & mdl_grant}, 32'd1);
    if (hold_pend) chk("hold_stable", {24'd0, out_data}, {24'd0, hold_data});
    hold_pend = out_valid && !out_ready && !rst;
    hold_data = out_data;
    if (rst) mdl_last = 1'b1;
    else if (req0_ready && req0_valid) mdl_last = 1'b0;
    else if (req1_ready && req1_valid) mdl_last = 1'b1;
  end

  initial begin
    rst = 1'b1; req0_valid = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_data = '0; out_ready = 1'b0;

    // Reset, with requesters valid to show readys stay low.
    drive(1, 0, 8'h00, 0, 8'h00, 0);
    drive(1, 1, 8'h12, 1, 8'h34, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'h00);
    chk("rst_out_src", {31'd0, out_src}, 32'd0);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd0);

    // Single word from requester 0, one-cycle latency.
    drive(0, 1, 8'hA5, 0, 8'h00, 1);
    chk("single_ready0", {31'd0, req0_ready}, 32'd1);
    chk("single_ready1", {31'd0, req1_ready}, 32'd0);
    chk("single_empty", {31'd0, out_valid}, 32'd0);
    drive(0, 0, 8'h00, 0, 8'h00, 1);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data", {24'd0, out_data}, 32'hA5);
    chk("single_src", {31'd0, out_src}, 32'd0);
    drive(0, 0, 8'h00, 0, 8'h00, 1);
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    chk("idle_ready0", {31'd0, req0_ready}, 32'd0);

    // Fresh reset, then contention for 4 cycles: 0,1,0,1.
    drive(1, 0, 8'h00, 0, 8'h00, 1);
    drive(0, 1, 8'h11, 1, 8'h22, 1);
    chk("rr_c0_ready0", {31'd0, req0_ready}, 32'd1);
    chk("rr_c0_ready1", {31'd0, req1_ready}, 32'd0);
    drive(0, 1, 8'h11, 1, 8'h22, 1);
    chk("rr_c1_src", {31'd0, out_src}, 32'd0);
    chk("rr_c1_data", {24'd0, out_data}, 32'h11);
    chk("rr_c1_ready1", {31'd0, req1_ready}, 32'd1);
    drive(0, 1, 8'h11, 1, 8'h22, 1);
    chk("rr_c2_src", {31'd0, out_src}, 32'd1);
    chk("rr_c2_data", {24'd0, out_data}, 32'h22);
    drive(0, 1, 8'h11, 1, 8'h22, 1);
    chk("rr_c3_src", {31'd0, out_src}, 32'd0);
    chk("rr_c3_data", {24'd0, out_data}, 32'h11);
    drive(0, 0, 8'h00, 0, 8'h00, 1);
    chk("rr_c4_src", {31'd0, out_src}, 32'd1);
    chk("rr_c4_data", {24'd0, out_data}, 32'h22);
    chk("rr_c4_valid", {31'd0, out_valid}, 32'd1);

    // Backpressure: fill with 44, stall 3 cycles with both valid.
    drive(0, 1, 8'h44, 0, 8'h00, 0);
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    chk("bp_fill_ready0", {31'd0, req0_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8'h55, 1, 8'h66, 0);
      chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
      chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
      chk("bp_data", {24'd0, out_data}, 32'h44);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
    end
    drive(0, 1, 8'h55, 1, 8'h66, 1);
    chk("bp_release_data", {24'd0, out_data}, 32'h44);
    chk("bp_release_ready1", {31'd0, req1_ready}, 32'd1);

    // Back-to-back: requester 1 alone while FULL and draining.
    drive(0, 0, 8'h00, 1, 8'h3C, 1);
    chk("bp_next_data", {24'd0, out_data}, 32'h66);
    chk("bp_next_src", {31'd0, out_src}, 32'd1);
    chk("b2b_ready1", {31'd0, req1_ready}, 32'd1);
    drive(1, 0, 8'h00, 0, 8'h00, 1);
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_data", {24'd0, out_data}, 32'h3C);

    // Reset while FULL discards the word; next contention goes to 0.
    drive(0, 1, 8'h77, 1, 8'h88, 1);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data", {24'd0, out_data}, 32'h00);
    chk("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_ready1", {31'd0, req1_ready}, 32'd0);
    drive(0, 0, 8'h00, 0, 8'h00, 1);
    chk("post_rst_src", {31'd0, out_src}, 32'd0);
    chk("post_rst_data", {24'd0, out_data}, 32'h77);

    drive(0, 0, 8'h00, 0, 8'h00, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
